result_readback_seq: RTL
========================

// Module: result_readback_seq
// PURPOSE
//  Synthesisable, parametrised readback sequencer for the multi-core result memory.
//  - Waits until every enabled core has asserted its end-of-process flag.
//  - Sweeps a programmable address window; each read result becomes one valid/ready stream beat.
//  - Sits between the core array (addr/result port) and the host/UART result path.
// PARAMETERS
//  NUM_CORES  4   number of end_process inputs
//  ADDR_W     12  result-memory address width
//  DATA_W     12  result word width
//  READ_LAT   1   cycles from addr_out change to result_in valid (>=1)
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous active-high reset
//  start        in   1          one-cycle pulse; begins a sweep (accepted only in IDLE)
//  core_mask    in   NUM_CORES  1 = core participates in the all-done check
//  addr_base    in   ADDR_W     first address; sampled on accepted start
//  addr_count   in   ADDR_W+1   number of words to read; sampled on accepted start
//  end_process  in   NUM_CORES  per-core done flags, level
//  addr_out     out  ADDR_W     read address to the core array
//  result_in    in   DATA_W     read data from the core array
//  out_data     out  DATA_W     captured result word
//  out_valid    out  1          out_data valid
//  out_ready    in   1          downstream accepts the beat when out_valid & out_ready
//  out_last     out  1          high with the final beat of a sweep
//  busy         out  1          high in every state except IDLE
//  done         out  1          one-cycle pulse at sweep completion
// BEHAVIOUR
//  Reset: state=IDLE; addr_out=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0; index=0.
//  all_done = &(end_process | ~core_mask); core_mask==0 gives all_done=1.
//  IDLE:  start -> latch base/count, index=0, go WAIT_DONE. start is ignored in any other state.
//  WAIT_DONE:
//    - all_done -> ISSUE.
//    - If count==0 -> FINISH instead; no beats are emitted.
//  ISSUE (1 cycle):
//    - Register addr_out = (base+index) mod 2^ADDR_W; the address wraps, with no error.
//    - Load the latency counter with READ_LAT -> WAIT_LAT.
//  WAIT_LAT:
//    - Decrement the counter.
//    - At 0: out_data<=result_in, out_valid<=1, out_last<=(index==count-1) -> OUTPUT.
//    - Timing: the beat appears READ_LAT+2 cycles after ISSUE entry.
//  OUTPUT:
//    - out_data and out_last stay stable while out_valid=1 and out_ready=0.
//    - On handshake: out_valid<=0, out_last<=0.
//      - Last beat -> FINISH.
//      - Otherwise index+1 -> CHECK.
//  CHECK (1 cycle):
//    - all_done -> ISSUE.
//    - Otherwise WAIT_DONE; the current index is re-issued once done re-asserts, so no word is skipped.
//  FINISH: done=1 for exactly one cycle -> IDLE (busy low the next cycle).
//  Back-to-back: start in the cycle after done is accepted normally.
//  all_done dropping during WAIT_LAT/OUTPUT does not abort the beat; it is checked only in CHECK.
//  Reset mid-sweep returns all outputs to their reset values immediately; no partial done pulse.
//  The state machine uses binary encoding; every register is reset by rst.
// TESTING
//  1. Basic sweep:
//     - Stimulus: READ_LAT=1, mask=4'hF, all done, base=0, count=4, out_ready=1.
//     - Response: 4 beats with addrs 0..3, out_last on beat 4, then done 1 cycle later.
//  2. Done gating: end_process=4'b0111, mask=4'hF -> no addr issued. Setting mask=4'h7 -> sweep proceeds.
//  3. Backpressure: out_ready=0 for 5 cycles on beat 2 -> out_valid/out_data held constant; no extra beats.
//  4. Edge counts and wrap:
//     - count=0 -> done pulse, zero beats.
//     - base=12'hFFE, count=4 -> addrs FFE, FFF, 000, 001.
//  5. Core drops done after beat 1 for 10 cycles -> sequencer stalls, then resumes at index 1; beat values match the memory model.
//  6. Reset and start handling:
//     - rst asserted during WAIT_LAT -> outputs return to reset values asynchronously.
//     - start during busy is ignored.
//     - READ_LAT=3 -> beat appears 5 cycles after ISSUE.

Source files
------------

// File: rtl/result_readback_seq.sv
// Readback sequencer: waits for all enabled cores to finish, then sweeps
// a result-memory address window and streams each word as a valid/ready beat.
// Ports:
//   clk, rst              clock, async active-high reset
//   start                 pulse, begins a sweep when idle
//   core_mask, end_process core participation mask and per-core done flags
//   addr_base, addr_count sweep window, sampled on accepted start
//   addr_out, result_in   read port to the core array
//   out_data, out_valid, out_ready, out_last   result stream
//   busy, done            status (done is a one-cycle completion pulse)
module result_readback_seq #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12,
  parameter int READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [ADDR_W-1:0]    addr_base,
  input  logic [ADDR_W:0]      addr_count,
  input  logic [NUM_CORES-1:0] end_process,
  output logic [ADDR_W-1:0]    addr_out,
  input  logic [DATA_W-1:0]    result_in,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int CW    = ADDR_W + 1;
  localparam int LAT_W = $clog2(READ_LAT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DONE = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_LAT  = 3'd3;
  localparam logic [2:0] S_OUTPUT    = 3'd4;
  localparam logic [2:0] S_CHECK     = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     count;
  logic [CW-1:0]     index;
  logic [LAT_W-1:0]  lat_cnt;
  logic              all_done;
  logic              is_last;

  // Masked-off cores count as finished.
  assign all_done = &(end_process | ~core_mask);
  assign is_last  = (index == count - CW'(1));

  // Decoded from state so reset clears them without a cycle of lag.
  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      base      <= '0;
      count     <= '0;
      index     <= '0;
      lat_cnt   <= '0;
      addr_out  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            base  <= addr_base;
            count <= addr_count;
            index <= '0;
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (count == '0) state <= S_FINISH;
          else if (all_done) state <= S_ISSUE;
        end
        S_ISSUE: begin
          // Window may run past the top of memory; it wraps.
          addr_out <= base + index[ADDR_W-1:0];
          lat_cnt  <= LAT_W'(READ_LAT);
          state    <= S_WAIT_LAT;
        end
        S_WAIT_LAT: begin
          if (lat_cnt == '0) begin
            out_data  <= result_in;
            out_valid <= 1'b1;
            out_last  <= is_last;
            state     <= S_OUTPUT;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= S_FINISH;
            end else begin
              index <= index + CW'(1);
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // A core dropping done parks us; the same index is re-issued.
          state <= all_done ? S_ISSUE : S_WAIT_DONE;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
